perf_event_aggregator: RTL and testbench



---
 rtl/perf_event_aggregator.sv | 111 +++++++++++
 tb/tb_perf_event_aggregator.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/perf_event_aggregator.sv
// Per-event popcount of raw event sources with hold-time pending accumulators feeding the perf counters.
// Optional saturation-drop counter output enabled by PERF_EVT_AGG_DROP_CNT_EN.
module perf_event_aggregator #(
  parameter int unsigned NrSrc     = 2,
  parameter int unsigned NumEvents = 32,
  parameter int unsigned OutW      = 2,
  parameter int unsigned PendW     = 4
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic [NrSrc-1:0][NumEvents-1:0]     evt_i,
  input  logic                                hold_i,
  input  logic                                clr_i,
  output logic [NumEvents-1:0][OutW-1:0]      evt_cnt_o,
  output logic [NumEvents-1:0]                pend_o,
  output logic [NumEvents-1:0]                lost_o
`ifdef PERF_EVT_AGG_DROP_CNT_EN
  ,
  output logic [15:0]                         drop_cnt_o
`endif
);

  localparam int unsigned InW  = $clog2(NrSrc + 1);
  localparam int unsigned TotW = ((PendW > InW) ? PendW : InW) + 1;
  localparam logic [TotW-1:0] OutMax  = TotW'((1 << OutW) - 1);
  localparam logic [TotW-1:0] PendMax = TotW'((1 << PendW) - 1);

  logic [NumEvents-1:0][PendW-1:0] pend_q, pend_d;
  logic [NumEvents-1:0][OutW-1:0]  out_q, out_d;
  logic [NumEvents-1:0]            lost_q, lost_d;
  logic [TotW-1:0]                 in_c, tot_c, out_c, rem_c;

`ifdef PERF_EVT_AGG_DROP_CNT_EN
  logic [31:0] drop_sum;
  logic [32:0] drop_acc;
  logic [15:0] drop_q, drop_d;
`endif

  always_comb begin
    pend_d = '0;
    out_d  = '0;
    lost_d = clr_i ? '0 : lost_q;
    in_c   = '0;
    tot_c  = '0;
    out_c  = '0;
    rem_c  = '0;
`ifdef PERF_EVT_AGG_DROP_CNT_EN
    drop_sum = '0;
`endif
    for (int e = 0; e < NumEvents; e++) begin
      in_c = '0;
      for (int s = 0; s < NrSrc; s++) begin
        in_c = in_c + TotW'(evt_i[s][e]);
      end
      if (e == 0) in_c = '0;
      // Clear discards the stored count but still accounts for this cycle's events.
      tot_c = in_c + (clr_i ? '0 : TotW'(pend_q[e]));
      if (hold_i) begin
        out_c = '0;
        rem_c = tot_c;
      end else begin
        out_c = (tot_c > OutMax) ? OutMax : tot_c;
        rem_c = tot_c - out_c;
      end
      out_d[e]  = out_c[OutW-1:0];
      pend_d[e] = (rem_c > PendMax) ? PendMax[PendW-1:0] : rem_c[PendW-1:0];
      if ((rem_c > PendMax) && !clr_i) lost_d[e] = 1'b1;
`ifdef PERF_EVT_AGG_DROP_CNT_EN
      if (rem_c > PendMax) drop_sum = drop_sum + 32'(rem_c - PendMax);
`endif
    end
  end

`ifdef PERF_EVT_AGG_DROP_CNT_EN
  always_comb begin
    drop_acc = {17'd0, drop_q} + {1'b0, drop_sum};
    drop_d   = (drop_acc > 33'h0FFFF) ? 16'hFFFF : drop_acc[15:0];
    if (clr_i) drop_d = '0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) drop_q <= '0;
    else         drop_q <= drop_d;
  end

  assign drop_cnt_o = drop_q;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= '0;
      out_q  <= '0;
      lost_q <= '0;
    end else begin
      pend_q <= pend_d;
      out_q  <= out_d;
      lost_q <= lost_d;
    end
  end

  always_comb begin
    pend_o = '0;
    for (int e = 0; e < NumEvents; e++) begin
      pend_o[e] = |pend_q[e];
    end
  end

  assign evt_cnt_o = out_q;
  assign lost_o    = lost_q;

endmodule

// File: tb/tb_perf_event_aggregator.sv
// Directed scoreboard bench for perf_event_aggregator (NrSrc=2, NumEvents=32, OutW=2, PendW=4).
module tb_perf_event_aggregator;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [1:0][31:0]  evt = '0;
  logic              hold = 1'b0;
  logic              clr = 1'b0;
  logic [31:0][1:0]  evt_cnt;
  logic [31:0]       pend;
  logic [31:0]       lost;
`ifdef PERF_EVT_AGG_DROP_CNT_EN
  logic [15:0]       drop;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0][1:0] cnt;
    logic [31:0]      pnd;
    logic [31:0]      lst;
  } exp_t;

  exp_t q[$];
  exp_t mx;

  perf_event_aggregator dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .evt_i     (evt),
    .hold_i    (hold),
    .clr_i     (clr),
    .evt_cnt_o (evt_cnt),
    .pend_o    (pend),
    .lost_o    (lost)
`ifdef PERF_EVT_AGG_DROP_CNT_EN
    ,
    .drop_cnt_o(drop)
`endif
  );

  always #5 clk = ~clk;

  // Monitor: each entry describes the registered outputs after the cycle it was issued for.
  always @(posedge clk) begin
    #2;
    if (q.size() > 0) begin
      mx = q.pop_front();
      checks++;
      if (evt_cnt !== mx.cnt) begin
        errors++;
        $display("FAIL evt_cnt got %h want %h", evt_cnt, mx.cnt);
      end
      checks++;
      if (pend !== mx.pnd) begin
        errors++;
        $display("FAIL pend got %h want %h", pend, mx.pnd);
      end
      checks++;
      if (lost !== mx.lst) begin
        errors++;
        $display("FAIL lost got %h want %h", lost, mx.lst);
      end
    end
  end

  task automatic step(input logic [31:0] e0, input logic [31:0] e1, input logic h,
                      input logic c, input int idx, input logic [1:0] cnt, input logic p,
                      input logic [31:0] lst);
    exp_t x;
    @(negedge clk);
    evt[0] = e0;
    evt[1] = e1;
    hold   = h;
    clr    = c;
    x      = '0;
    x.cnt[idx] = cnt;
    x.pnd[idx] = p;
    x.lst      = lst;
    q.push_back(x);
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (evt_cnt !== '0 || pend !== '0 || lost !== '0) begin
      errors++;
      $display("FAIL %s cnt=%h pend=%h lost=%h want all 0", name, evt_cnt, pend, lost);
    end
  endtask

  task automatic drain_q();
    int n;
    n = 0;
    while (q.size() > 0 && n < 20) begin
      @(posedge clk);
      #3;
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain left %0d want 0", q.size());
      q.delete();
    end
  endtask

`ifdef PERF_EVT_AGG_DROP_CNT_EN
  task automatic check_drop(input logic [15:0] want);
    @(posedge clk);
    #2;
    checks++;
    if (drop !== want) begin
      errors++;
      $display("FAIL drop_cnt got %0d want %0d", drop, want);
    end
  endtask
`endif

  localparam logic [31:0] L12 = 32'h0000_1000;

  initial begin
    #2 rst_n = 1'b0;
    #2 check_zero("reset_state");
    #12 rst_n = 1'b1;

    // single-cycle increment, latency 1
    step(32'h20, 32'h20, 0, 0, 5, 2, 0, 0);
    step(0, 0, 0, 0, 5, 0, 0, 0);

    // hold 4 cycles with 8 events on id 9, then drain 3,3,2,0
    for (int i = 0; i < 4; i++) step(32'h200, 32'h200, 1, 0, 9, 0, 1, 0);
    step(0, 0, 0, 0, 9, 3, 1, 0);
    step(0, 0, 0, 0, 9, 3, 1, 0);
    step(0, 0, 0, 0, 9, 2, 0, 0);
    step(0, 0, 0, 0, 9, 0, 0, 0);

    // 20 events on id 12 under hold: saturates at 15, lost from the 8th cycle
    for (int i = 1; i <= 10; i++)
      step(32'h1000, 32'h1000, 1, 0, 12, 0, 1, (i >= 8) ? L12 : 32'h0);
`ifdef PERF_EVT_AGG_DROP_CNT_EN
    check_drop(16'd5);
`endif
    for (int i = 1; i <= 5; i++) step(0, 0, 0, 0, 12, 3, (i < 5) ? 1'b1 : 1'b0, L12);
    step(0, 0, 0, 0, 12, 0, 0, L12);

    // pending[3]=6 plus 2 new: output 3, pending 5
    for (int i = 0; i < 3; i++) step(32'h8, 32'h8, 1, 0, 3, 0, 1, L12);
    step(32'h8, 32'h8, 0, 0, 3, 3, 1, L12);
    step(0, 0, 0, 0, 3, 3, 1, L12);
    step(0, 0, 0, 0, 3, 2, 0, L12);
    // same situation with clear: output 2, pending 0, lost cleared
    for (int i = 0; i < 3; i++) step(32'h8, 32'h8, 1, 0, 3, 0, 1, L12);
    step(32'h8, 32'h8, 0, 1, 3, 2, 0, 0);
`ifdef PERF_EVT_AGG_DROP_CNT_EN
    check_drop(16'd0);
`endif
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // event 0 never counts, pends or overflows
    for (int i = 0; i < 9; i++) step(32'h1, 32'h1, 1, 0, 0, 0, 0, 0);
    step(32'h1, 32'h1, 0, 0, 0, 0, 0, 0);
    step(32'h1, 32'h1, 0, 1, 0, 0, 0, 0);
    step(32'h21, 32'h21, 0, 0, 5, 2, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // build pending[7]=10, drain partially, then async reset
    for (int i = 0; i < 5; i++) step(32'h80, 32'h80, 1, 0, 7, 0, 1, 0);
    step(0, 0, 0, 0, 7, 3, 1, 0);
    step(0, 0, 0, 0, 7, 3, 1, 0);
    drain_q();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_zero("async_reset_mid_drain");
    @(posedge clk);
    #2 check_zero("reset_held");
    @(negedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    drain_q();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout reached want finish before 100000");
    $fatal(1, "timeout");
  end

endmodule
